// File: rtl/add_4.sv
// Purpose: registered WIDTH-bit ripple-carry adder with carry-in and carry-out for cascading.
// Latency: 1 cycle from in_valid to out_valid; s/cy4 hold their last result while idle.
// Backpressure: none; accepts one operand pair every cycle.
module add_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] s,
    output logic             cy4,
    input  logic             cy_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Carry is kept as a running scalar so the chain reads as one full-adder cell per bit.
    always_comb begin : ripple
        logic carry;
        carry = cy_in;
        sum_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_c[i] = x[i] ^ y[i] ^ carry;
            carry    = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
        end
        cout_c = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            cy4       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s   <= sum_c;
                cy4 <= cout_c;
            end
        end
    end

endmodule

// File: tb/tb_add_4.sv
// Directed and exhaustive checks of add_4; the driver queues one expected
// {out_valid, cy4, s} per clock and an independent monitor compares after each edge.
module tb_add_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] s;
    logic       cy4;
    logic       cy_in;
    logic [3:0] x;
    logic [3:0] y;
    logic       in_valid;
    logic       out_valid;

    int vectors;
    int miscompares;

    logic [5:0] exp_q[$];

    add_4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .cy4      (cy4),
        .cy_in    (cy_in),
        .x        (x),
        .y        (y),
        .in_valid (in_valid),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = {out_valid, cy4, s};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got v=%b cy=%b s=%b, want v=%b cy=%b s=%b",
                     name, got[5], got[4], got[3:0], want[5], want[4], want[3:0]);
        end
    endtask

    // One clock of stimulus; the expected response for the following edge is queued.
    task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic exp_cy, input logic [3:0] exp_s);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = v;
        x        = a;
        y        = b;
        cy_in    = c;
        exp_q.push_back({v, exp_cy, exp_s});
    endtask

    // Monitor: after every rising edge, outputs must be zero in reset or match the queue head.
    initial begin
        logic [5:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("in_reset", 6'b0);
            end else if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("scoreboard", want);
            end
        end
    end

    initial begin
        logic [4:0] e;
        logic [3:0] a;
        logic [3:0] b;
        vectors     = 0;
        miscompares = 0;

        // Reset with arbitrary operands applied.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 4'b1010;
        y        = 4'b0111;
        cy_in    = 1'b1;
        #1;
        check("reset_immediate", 6'b0);
        repeat (3) @(negedge clk);

        // Released but idle: outputs stay zero.
        cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0000);

        // Directed cases.
        cycle(1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0011);
        cycle(1'b1, 4'b0010, 4'b1000, 1'b0, 1'b0, 4'b1010);
        cycle(1'b1, 4'b1110, 4'b1001, 1'b0, 1'b1, 4'b0111);
        cycle(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000);

        // Back-to-back results, then idle cycles hold the last result.
        cycle(1'b1, 4'b0101, 4'b0011, 1'b1, 1'b0, 4'b1001);
        cycle(1'b1, 4'b1000, 4'b1000, 1'b0, 1'b1, 4'b0000);
        cycle(1'b1, 4'b0111, 4'b0110, 1'b1, 1'b0, 4'b1110);
        cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1110);
        cycle(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b1110);

        // Async reset between edges while a valid result is showing.
        cycle(1'b1, 4'b0011, 4'b0100, 1'b0, 1'b0, 4'b0111);
        cycle(1'b1, 4'b1001, 4'b1001, 1'b1, 1'b1, 4'b0011);
        @(posedge clk);
        #3;
        check("pre_reset", 6'b1_1_0011);
        rst_n = 1'b0;
        #1;
        check("async_reset", 6'b0);
        exp_q.delete();
        @(negedge clk);
        cycle(1'b0, 4'b1100, 4'b0011, 1'b1, 1'b0, 4'b0000);

        // Exhaustive sweep of x, y, cy_in.
        for (int i = 0; i < 512; i++) begin
            a = i[3:0];
            b = i[7:4];
            e = {1'b0, a} + {1'b0, b} + {4'b0, i[8]};
            cycle(1'b1, a, b, i[8], e[4], e[3:0]);
        end
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111);

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results never checked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add_4.md
Name: add_4

Overview:
- 4-bit ripple-carry adder with registered outputs.
- Sum is formed by a chain of WIDTH one-bit full-adder cells; carry ripples from bit 0 to bit WIDTH-1.
- Result and carry-out are captured on the clock edge.
- Used as a small arithmetic leaf in datapaths that need a registered sum plus carry-out for cascading.

Parameters:
- WIDTH, 4, operand and sum width in bits (must be >= 1).

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- s  output  WIDTH  registered sum bits.
- cy4  output  1  registered carry-out of the MSB full adder.
- cy_in  input  1  carry-in to bit 0.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- in_valid  input  1  qualifies x, y and cy_in this cycle.
- out_valid  output  1  s and cy4 hold a result computed from a valid input.

Behaviour:
- Datapath structure:
  - Combinational ripple chain: c[0] = cy_in.
  - For i = 0..WIDTH-1: sum_i = x[i] ^ y[i] ^ c[i]; c[i+1] = (x[i]&y[i]) | (x[i]&c[i]) | (y[i]&c[i]).
  - Carry-out is c[WIDTH].
  - Equivalent arithmetic: {cy4, s} = x + y + cy_in, computed (WIDTH+1) bits wide, unsigned, no saturation.
  - Overflow wraps modulo 2^WIDTH; the lost bit appears on cy4.
- Reset:
  - rst_n low asynchronously forces s = 0, cy4 = 0, out_valid = 0, regardless of clk.
  - The values hold while rst_n stays low.
- Release:
  - Deassertion of rst_n takes effect at the next rising clk edge.
  - First capture happens at the first rising edge where rst_n is high.
- Latency:
  - Exactly 1 cycle. On a rising edge with in_valid = 1, s and cy4 load the sum of the x, y, cy_in values present before that edge, and out_valid is set to 1.
  - On a rising edge with in_valid = 0, s and cy4 hold their previous values and out_valid is cleared to 0.
- Throughput: one addition per cycle. Back-to-back valid inputs produce back-to-back results, with no bubbles and no backpressure.
- Reset mid-operation: a result pending on the same edge as an asynchronous reset is discarded. Outputs read 0 and out_valid reads 0.
- Inputs with X/Z are not defined; the bench drives only known values.
- No internal state beyond the WIDTH+2 output flops.

Test Plan:
- Reset: hold rst_n = 0 with arbitrary x/y -> s = 0000, cy4 = 0, out_valid = 0, both immediately and across clocks. Release rst_n -> outputs still 0 until the first valid edge.
- Basic add: x = 0001, y = 0010, cy_in = 0, in_valid = 1 -> next edge: s = 0011, cy4 = 0, out_valid = 1.
- No-carry MSB: x = 0010, y = 1000, cy_in = 0 -> s = 1010, cy4 = 0.
- Carry out: x = 1110, y = 1001, cy_in = 0 -> s = 0111, cy4 = 1. Full ripple: x = 1111, y = 0000, cy_in = 1 -> s = 0000, cy4 = 1.
- Hold and pipelining:
  - Three consecutive valid inputs -> three consecutive results, each 1 cycle late.
  - Then in_valid = 0 with new x/y -> s and cy4 unchanged, out_valid = 0.
- Async reset mid-stream: assert rst_n low between edges while out_valid = 1 -> s, cy4 and out_valid go to 0 before the next edge.
- Exhaustive: sweep all 512 combinations of x, y, cy_in with in_valid = 1 -> each result matches x + y + cy_in one cycle later.
